ucdp_latch_file: RTL and testbench



---
 rtl/ucdp_latch_file.sv | 169 ++++++++++++++++
 tb/tb_ucdp_latch_file.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ucdp_latch_file.sv
// ucdp_latch_file: latch-based register file with one masked write port,
// one combinational read port, a sequential clear engine and write-drop
// reporting. Under FPGA the latch cells are replaced by flops.
module ucdp_latch_file #(
  parameter int unsigned           width_p  = 8,
  parameter int unsigned           depth_p  = 4,
  parameter logic [width_p-1:0]    rstval_p = {width_p{1'b0}},
  localparam int unsigned          addrw_p  = $clog2(depth_p)
) (
  input  logic               main_clk_i,
  input  logic               main_rst_i,
  input  logic               wr_en_i,
  input  logic [addrw_p-1:0] wr_addr_i,
  input  logic [width_p-1:0] wr_data_i,
  input  logic [width_p-1:0] wr_mask_i,
  output logic               wr_drop_o,
  input  logic               clr_i,
  output logic               busy_o,
  input  logic [addrw_p-1:0] rd_addr_i,
  output logic [width_p-1:0] rd_data_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic [addrw_p-1:0] LAST_ADDR = addrw_p'(depth_p - 1);

  state_e             state_q, state_d;
  logic [addrw_p-1:0] cnt_q, cnt_d;
  // Capture flops: the write (user or clear) that owns the low phase of
  // the current cycle. Latch enables are derived only from these.
  logic               wen_q, wen_d;
  logic [addrw_p-1:0] waddr_q, waddr_d;
  logic [width_p-1:0] wdata_q, wdata_d;
  logic [width_p-1:0] wmask_q, wmask_d;
  logic               drop_q, drop_d;

  logic               wr_in_range;
  logic [depth_p-1:0] ent_en;
  logic [depth_p-1:0][width_p-1:0] ent;

  assign wr_in_range = 32'(wr_addr_i) < depth_p;

  // Next-state: clear sequencing, write arbitration and drop detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          // Clear wins over a same-edge write; entry 0 is cleared first.
          state_d = CLEAR;
          cnt_d   = '0;
          wen_d   = 1'b1;
          waddr_d = '0;
          wdata_d = rstval_p;
          wmask_d = '1;
          drop_d  = wr_en_i;
        end else if (wr_en_i) begin
          if (!wr_in_range) begin
            drop_d = 1'b1;
          end else if (|wr_mask_i) begin
            wen_d   = 1'b1;
            waddr_d = wr_addr_i;
            wdata_d = wr_data_i;
            wmask_d = wr_mask_i;
          end
        end
      end
      CLEAR: begin
        // User writes are discarded for the whole sequence; clr_i ignored.
        drop_d = wr_en_i;
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + addrw_p'(1);
          wen_d   = 1'b1;
          waddr_d = cnt_q + addrw_p'(1);
          wdata_d = rstval_p;
          wmask_d = '1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and capture registers.
  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      drop_q  <= drop_d;
    end
  end

  assign busy_o    = (state_q == CLEAR);
  assign wr_drop_o = drop_q;

  // Entry decode from the capture flops only.
  always_comb begin
    ent_en = '0;
    for (int i = 0; i < int'(depth_p); i++) begin
      ent_en[i] = wen_q && (waddr_q == addrw_p'(i));
    end
  end

  for (genvar i = 0; i < int'(depth_p); i++) begin : g_ent
`ifdef FPGA
    logic [width_p-1:0] ent_r;
    // Flop storage updated at the edge closing the write cycle; that edge
    // is the same one at which the latch build's new value becomes stable,
    // so no extra bypass is required at the read port.
    always_ff @(posedge main_clk_i or posedge main_rst_i) begin
      if (main_rst_i) begin
        ent_r <= rstval_p;
      end else if (ent_en[i]) begin
        ent_r <= (ent_r & ~wmask_q) | (wdata_q & wmask_q);
      end
    end
    assign ent[i] = ent_r;
`else
    for (genvar b = 0; b < int'(width_p); b++) begin : g_bit
      logic bit_q;
      logic le;
      // Per-bit enable makes the mask a plain gate: unmasked bits simply
      // stay closed, so no read-modify-write loop through the latch.
      assign le = ent_en[i] & wmask_q[b] & ~main_clk_i;
      // Storage latch, forced transparent to the reset value by reset.
      always_latch begin
        if (main_rst_i) begin
          bit_q <= rstval_p[b];
        end else if (le) begin
          bit_q <= wdata_q[b];
        end
      end
      assign ent[i][b] = bit_q;
    end
`endif
  end

  // Combinational read; out-of-range addresses return the reset value.
  always_comb begin
    rd_data_o = rstval_p;
    for (int i = 0; i < int'(depth_p); i++) begin
      if (rd_addr_i == addrw_p'(i)) rd_data_o = ent[i];
    end
  end

endmodule

// File: tb/tb_ucdp_latch_file.sv
// Scoreboard bench for ucdp_latch_file: two instances (depth 4 and 5)
// share stimulus; a cycle-level reference model predicts outputs.
module tb_ucdp_latch_file;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, clr;
  logic [1:0] wa4, ra4;
  logic [2:0] wa5, ra5;
  logic [7:0] wd, wm;
  logic [7:0] rd4, rd5;
  logic       drop4, drop5, busy4, busy5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ucdp_latch_file #(.width_p(8), .depth_p(4), .rstval_p(RV)) u_d4 (
    .main_clk_i(clk), .main_rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wa4),
    .wr_data_i(wd), .wr_mask_i(wm), .wr_drop_o(drop4), .clr_i(clr),
    .busy_o(busy4), .rd_addr_i(ra4), .rd_data_o(rd4));

  ucdp_latch_file #(.width_p(8), .depth_p(5), .rstval_p(RV)) u_d5 (
    .main_clk_i(clk), .main_rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wa5),
    .wr_data_i(wd), .wr_mask_i(wm), .wr_drop_o(drop5), .clr_i(clr),
    .busy_o(busy5), .rd_addr_i(ra5), .rd_data_o(rd5));

  typedef struct packed {
    logic [7:0] rd0;
    logic [7:0] rd1;
    logic       b0, b1, d0, d1;
  } exp_t;

  exp_t q[$];

  // Reference model: visible contents, one write in flight per instance,
  // remaining clear cycles, and the drop flag for the current cycle.
  int         dep[2] = '{4, 5};
  logic [7:0] mem[2][8];
  logic       pend_v[2];
  int         pend_a[2];
  logic [7:0] pend_d[2], pend_m[2];
  int         clr_left[2], clr_idx[2];
  logic       drop_f[2];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 8; a++) mem[m][a] = RV;
      pend_v[m] = 1'b0; pend_a[m] = 0; pend_d[m] = '0; pend_m[m] = '0;
      clr_left[m] = 0; clr_idx[m] = 0; drop_f[m] = 1'b0;
    end
  endtask

  // One clock cycle: drive inputs, push expected outputs for this cycle,
  // then advance the model across the following edge.
  task automatic cycle(input logic en, input logic [2:0] wa, input logic [7:0] d,
                       input logic [7:0] mk, input logic c, input logic [2:0] ra);
    int   aw[2], ar[2];
    logic [7:0] er[2];
    exp_t e;
    @(posedge clk); #1;
    wr_en = en; wa4 = wa[1:0]; wa5 = wa; wd = d; wm = mk; clr = c;
    ra4 = ra[1:0]; ra5 = ra;
    aw[0] = int'(wa[1:0]); aw[1] = int'(wa);
    ar[0] = int'(ra[1:0]); ar[1] = int'(ra);
    for (int m = 0; m < 2; m++) er[m] = (ar[m] < dep[m]) ? mem[m][ar[m]] : RV;
    e.rd0 = er[0]; e.rd1 = er[1];
    e.b0 = clr_left[0] > 0; e.b1 = clr_left[1] > 0;
    e.d0 = drop_f[0]; e.d1 = drop_f[1];
    q.push_back(e);
    for (int m = 0; m < 2; m++) begin
      if (pend_v[m])
        mem[m][pend_a[m]] = (mem[m][pend_a[m]] & ~pend_m[m]) | (pend_d[m] & pend_m[m]);
      pend_v[m] = 1'b0;
      drop_f[m] = 1'b0;
      if (clr_left[m] > 0) begin
        clr_left[m]--;
        clr_idx[m]++;
        if (clr_left[m] > 0) begin
          pend_v[m] = 1'b1; pend_a[m] = clr_idx[m]; pend_d[m] = RV; pend_m[m] = 8'hFF;
        end
        drop_f[m] = en;
      end else if (c) begin
        clr_left[m] = dep[m]; clr_idx[m] = 0;
        pend_v[m] = 1'b1; pend_a[m] = 0; pend_d[m] = RV; pend_m[m] = 8'hFF;
        drop_f[m] = en;
      end else if (en) begin
        if (aw[m] >= dep[m]) drop_f[m] = 1'b1;
        else if (mk != 8'h00) begin
          pend_v[m] = 1'b1; pend_a[m] = aw[m]; pend_d[m] = d; pend_m[m] = mk;
        end
      end
    end
  endtask

  // Monitor: compares the DUT against the head of the scoreboard each cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("rd_d4",   rd4, e.rd0);
        check("rd_d5",   rd5, e.rd1);
        check("busy_d4", {7'd0, busy4}, {7'd0, e.b0});
        check("busy_d5", {7'd0, busy5}, {7'd0, e.b1});
        check("drop_d4", {7'd0, drop4}, {7'd0, e.d0});
        check("drop_d5", {7'd0, drop5}, {7'd0, e.d1});
      end
    end
  end

  initial begin
    logic [7:0] mk;
    rst = 1'b1; wr_en = 1'b0; clr = 1'b0; wa4 = '0; wa5 = '0; wd = '0; wm = '0;
    ra4 = '0; ra5 = '0;
    model_reset();
    #2;
    check("rst_busy", {6'd0, busy4, busy5}, 8'h00);
    check("rst_drop", {6'd0, drop4, drop5}, 8'h00);
    check("rst_rd4", rd4, RV);
    @(posedge clk); #1; rst = 1'b0;

    // Reset contents.
    for (int a = 0; a < 5; a++) cycle(0, 3'(a), 8'h00, 8'h00, 0, 3'(a));

    // Full write: old value in the capture cycle, new value afterwards.
    cycle(1, 3'd2, 8'h3C, 8'hFF, 0, 3'd2);
    cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'd2);
    cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'd2);
    for (int a = 0; a < 4; a++) cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'(a));

    // Masked write, then an all-zero mask write.
    cycle(1, 3'd1, 8'h00, 8'hFF, 0, 3'd1);
    cycle(1, 3'd1, 8'hFF, 8'h0F, 0, 3'd1);
    cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'd1);
    cycle(1, 3'd1, 8'h00, 8'h00, 0, 3'd1);
    cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'd1);
    cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'd1);

    // Out-of-range write on the depth-5 instance; out-of-range reads.
    cycle(1, 3'd7, 8'h55, 8'hFF, 0, 3'd6);
    cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'd6);
    cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'd7);
    for (int a = 0; a < 5; a++) cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'(a));

    // Fill, then clear together with a write; writes during busy.
    for (int a = 0; a < 5; a++) cycle(1, 3'(a), 8'h10 + 8'(a), 8'hFF, 0, 3'(a));
    cycle(1, 3'd0, 8'hEE, 8'hFF, 1, 3'd0);
    for (int i = 0; i < 7; i++) cycle(1'(i % 2), 3'(i), 8'h77, 8'hFF, 0, 3'(i));
    for (int a = 0; a < 5; a++) cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'(a));

    // Asynchronous reset in the middle of the second clear cycle.
    for (int a = 0; a < 5; a++) cycle(1, 3'(a), 8'h20 + 8'(a), 8'hFF, 0, 3'(a));
    cycle(0, 3'd0, 8'h00, 8'h00, 1, 3'd3);
    cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'd3);
    cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'd4);
    #5; rst = 1'b1; #1;
    check("arst_busy", {6'd0, busy4, busy5}, 8'h00);
    check("arst_drop", {6'd0, drop4, drop5}, 8'h00);
    for (int a = 0; a < 5; a++) begin
      ra4 = 2'(a); ra5 = 3'(a); #1;
      check("arst_rd4", rd4, RV);
      check("arst_rd5", rd5, RV);
    end
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0; clr = 1'b0; wm = '0;
    model_reset();
    cycle(1, 3'd3, 8'h5A, 8'hFF, 0, 3'd3);
    cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'd3);
    cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'd3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       mk = 8'h00;
        1:       mk = 8'hFF;
        default: mk = 8'($urandom);
      endcase
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom), mk,
            $urandom_range(0, 19) == 0, 3'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 6; i++) cycle(0, 3'd0, 8'h00, 8'h00, 0, 3'(i));

    @(posedge clk); #5;
    check("sb_drain", 8'(q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
